logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one combinational 32-bit logic unit (3-bit op: 000 AND, 001 XOR, 010 NAND, 011 OR, 100 NOT A, 101 NOR, 110 two's-complement of A, 111 XNOR) between NREQ VLIW issue slots.
- Round-robin grant, valid/ready handshake on both sides.
- One registered result stage tagged with requester ID, feeding writeback.
- Sits between slot decode and the LU instance; the LU is instantiated outside and wired through the lu_* ports.

Parameters:
- NREQ, 4, number of requesting issue slots (2..8).
- WIDTH, 32, operand/result width.
- IDW, 2, requester-ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-slot request valid
- req_ready  out  NREQ  per-slot accept; one-hot or zero
- req_op  in  3*NREQ  slot i op at [3i+2:3i]
- req_a  in  WIDTH*NREQ  slot i operand A
- req_b  in  WIDTH*NREQ  slot i operand B
- lu_op  out  3  op to the shared LU
- lu_a  out  WIDTH  operand A to the LU
- lu_b  out  WIDTH  operand B to the LU
- lu_c  in  WIDTH  LU result, combinational from lu_*
- res_valid  out  1  result register holds valid data
- res_ready  in  1  writeback accepts result
- res_data  out  WIDTH  registered result
- res_id  out  IDW  slot that issued res_data

Behaviour:
- Reset (async assert, sync deassert handled externally): res_valid=0, res_data=0, res_id=0, rr_ptr=0, state=EMPTY. req_ready=0 while rst_n=0.
- States: EMPTY (output register free) and FULL (res_valid=1).
- can_accept = (state==EMPTY) | (res_ready & res_valid).
- Grant is combinational: the first i with req_valid[i]=1, searching from rr_ptr upward with wrap NREQ-1 -> 0. req_ready[i]=1 only for the granted slot, and only when can_accept.
- lu_op/lu_a/lu_b are muxed from the granted slot. With no grant they are 000/0/0; never z or x.
- Accept (req_valid[g] & req_ready[g]) on edge k: res_data<=lu_c, res_id<=g, res_valid<=1 at k+1. Latency is exactly 1 cycle. rr_ptr<=(g+1) mod NREQ.
- No accept: rr_ptr unchanged.
- FULL & ~res_ready: res_data/res_id held stable, all req_ready=0, no new grant.
- FULL & res_ready & accept in the same cycle: new result loaded, res_valid stays 1. Back-to-back throughput is 1 per cycle.
- FULL & res_ready & no request: state -> EMPTY, res_valid=0. res_data keeps its last value.
- Requesters must hold op/A/B stable while valid & ~ready; the arbiter does not latch inputs before accept.
- Reset mid-operation: a pending result is discarded, rr_ptr returns to 0, and no spurious res_valid appears after release.
- Ops are passed through unmodified; unknown op handling belongs to the LU.

Optional Feature:
- Macro: LUARB_STALL_CNT_EN.
- Defined: adds port stall_cnt out 16.
  - Counts cycles with res_valid & ~res_ready.
  - Saturates at 0xFFFF.
  - Cleared by rst_n only.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Slot0 only, op=000, A=0x000000DB, B=0x000000BC, res_ready=1 -> next cycle res_valid=1, res_data=0x00000098, res_id=0.
- Slot2 only, op=001, same A/B -> res_data=0x00000067, res_id=2. Then op=110, A=5 -> res_data=0xFFFFFFFB.
- All 4 slots valid continuously, res_ready=1, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; res_id sequence 0,1,2,3,0; one result per cycle.
- Slots 1 and 3 valid, res_ready=0 after first accept -> slot1 result held 5 cycles, req_ready=0 throughout. On res_ready=1, slot3 accepted in the same cycle. With LUARB_STALL_CNT_EN, stall_cnt=5.
- rst_n pulsed low while res_valid=1 -> res_valid=0 immediately; after release, slot0 is granted first with all slots valid.
- Idle, no requests -> lu_op=000, lu_a=0, lu_b=0, req_ready=0, res_valid stays 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Shares one external combinational 32-bit logic unit between NREQ issue
// slots. A round-robin arbiter picks one requesting slot per cycle and drives
// its op/operands to the LU through the lu_* ports. The LU result is captured
// in a single result register tagged with the requester ID, which then feeds
// writeback through a valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-slot request handshake (req_ready one-hot or zero)
//   req_op/req_a/req_b   packed per-slot op (3b) and operands (WIDTH)
//   lu_op/lu_a/lu_b      operands to the shared LU (zero when nothing granted)
//   lu_c                 combinational LU result
//   res_valid/res_ready  result handshake towards writeback
//   res_data/res_id      registered result and the slot that issued it
//   stall_cnt            (LUARB_STALL_CNT_EN only) saturating count of cycles
//                        with res_valid & ~res_ready
//
// Optional feature macro: LUARB_STALL_CNT_EN

module logic_unit_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [2:0]            lu_op,
  output logic [WIDTH-1:0]      lu_a,
  output logic [WIDTH-1:0]      lu_b,
  input  logic [WIDTH-1:0]      lu_c,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id
`ifdef LUARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned OPW  = 3;
  localparam int unsigned CNTW = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  logic             can_accept;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand_idx;
  int unsigned      cand;
  logic             accept;

  // Output register is free, or is being drained this very cycle.
  assign can_accept = (state_q == EMPTY) | (res_ready & (state_q == FULL));

  // Round-robin search: first valid slot starting at rr_q, wrapping to 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // Reset gating keeps req_ready low while rst_n is asserted.
  assign accept = gnt_found & can_accept & rst_n;

  // Grant one-hot and operand mux; all zero when nothing is accepted.
  always_comb begin
    req_ready = '0;
    lu_op     = '0;
    lu_a      = '0;
    lu_b      = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
      lu_op = req_op[32'(gnt_idx)*OPW +: OPW];
      lu_a  = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
      lu_b  = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
    end
  end

  // Next-state: load on accept, drain to EMPTY when writeback takes the result.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    if (accept) begin
      state_d    = FULL;
      res_data_d = lu_c;
      res_id_d   = gnt_idx;
      if (gnt_idx == IDW'(NREQ - 1)) rr_d = '0;
      else                           rr_d = gnt_idx + IDW'(1);
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rr_q       <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

`ifdef LUARB_STALL_CNT_EN
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where writeback back-pressures a valid result.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == FULL) && !res_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: bench-side LU, cycle model of the
// round-robin arbiter and a result scoreboard queue.
module tb_logic_unit_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [2:0]            lu_op;
  logic [WIDTH-1:0]      lu_a;
  logic [WIDTH-1:0]      lu_b;
  logic [WIDTH-1:0]      lu_c;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
`ifdef LUARB_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  logic [2:0]       s_op [NREQ];
  logic [WIDTH-1:0] s_a  [NREQ];
  logic [WIDTH-1:0] s_b  [NREQ];

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .lu_op     (lu_op),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_c      (lu_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
`ifdef LUARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] lu_fn(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a ^ b;
      3'b010:  return ~(a & b);
      3'b011:  return a | b;
      3'b100:  return ~a;
      3'b101:  return ~(a | b);
      3'b110:  return (~a) + WIDTH'(1);
      default: return ~(a ^ b);
    endcase
  endfunction

  // External LU instance modelled in the bench.
  assign lu_c = lu_fn(lu_op, lu_a, lu_b);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]         = s_op[i];
      req_a[WIDTH*i +: WIDTH]  = s_a[i];
      req_b[WIDTH*i +: WIDTH]  = s_b[i];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } res_t;

  res_t             sb_q[$];
  bit               m_full;
  int               m_rr;
  logic [WIDTH-1:0] m_data;
  logic [IDW-1:0]   m_id;
  int               m_stall;

  task automatic model_reset();
    m_full  = 1'b0;
    m_rr    = 0;
    m_data  = '0;
    m_id    = '0;
    m_stall = 0;
    sb_q.delete();
  endtask

  task automatic set_slot(input int i, input logic [2:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    s_op[i] = op;
    s_a[i]  = a;
    s_b[i]  = b;
  endtask

  // One clock cycle: inputs already driven (after negedge). Check grant side,
  // push expected result, cross the edge, pop and check result side.
  task automatic cycle();
    int               g;
    logic [NREQ-1:0]  exp_rdy;
    logic [2:0]       eop;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    res_t             r;
    #1;
    g = -1;
    if (!m_full || res_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_rr + k) % NREQ;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_rdy = '0;
    eop = '0;
    ea  = '0;
    eb  = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      eop = s_op[g];
      ea  = s_a[g];
      eb  = s_b[g];
      sb_q.push_back('{id: IDW'(g), data: lu_fn(eop, ea, eb)});
    end
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("lu_op", 64'(lu_op), 64'(eop));
    check_eq("lu_a", 64'(lu_a), 64'(ea));
    check_eq("lu_b", 64'(lu_b), 64'(eb));
    if (m_full && !res_ready && m_stall < 65535) m_stall++;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard: queue empty, expected one entry");
      end else begin
        r = sb_q.pop_front();
        m_data = r.data;
        m_id   = r.id;
      end
      m_full = 1'b1;
      m_rr   = (g + 1) % NREQ;
    end else if (m_full && res_ready) begin
      m_full = 1'b0;
    end
    check_eq("res_valid", 64'(res_valid), 64'(m_full));
    check_eq("res_data", 64'(res_data), 64'(m_data));
    check_eq("res_id", 64'(res_id), 64'(m_id));
`ifdef LUARB_STALL_CNT_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [IDW-1:0] rr_seq [5];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    model_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_slot(i, 3'b011, 32'hFFFF_0000, 32'h0000_FFFF);
    repeat (2) @(negedge clk);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_res_data", 64'(res_data), 64'd0);
    check_eq("rst_res_id", 64'(res_id), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Slot 0 AND.
    set_slot(0, 3'b000, 32'h0000_00DB, 32'h0000_00BC);
    req_valid = 4'b0001;
    cycle();
    check_eq("tp_and_data", 64'(res_data), 64'h98);
    check_eq("tp_and_id", 64'(res_id), 64'd0);

    // Slot 2 XOR then two's complement, back to back.
    req_valid = 4'b0100;
    set_slot(2, 3'b001, 32'h0000_00DB, 32'h0000_00BC);
    cycle();
    check_eq("tp_xor_data", 64'(res_data), 64'h67);
    check_eq("tp_xor_id", 64'(res_id), 64'd2);
    set_slot(2, 3'b110, 32'h0000_0005, 32'h0000_00BC);
    cycle();
    check_eq("tp_neg_data", 64'(res_data), 64'hFFFF_FFFB);
    req_valid = '0;
    cycle();
    check_eq("drain_valid", 64'(res_valid), 64'd0);

    // Slot 3 alone moves the pointer back to 0.
    set_slot(3, 3'b111, 32'h1234_5678, 32'h0F0F_0F0F);
    req_valid = 4'b1000;
    cycle();

    // All slots valid: strict rotation, one result per cycle.
    for (int i = 0; i < NREQ; i++) set_slot(i, 3'(i + 1), $urandom, $urandom);
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check_eq("rr_seq_id", 64'(res_id), 64'(rr_seq[n]));
    end

    // Slots 1 and 3 with writeback stall.
    req_valid = 4'b1010;
    res_ready = 1'b1;
    cycle();
    check_eq("stall_first_id", 64'(res_id), 64'd1);
    res_ready = 1'b0;
    repeat (5) cycle();
    check_eq("stall_held_id", 64'(res_id), 64'd1);
    res_ready = 1'b1;
    cycle();
    check_eq("stall_next_id", 64'(res_id), 64'd3);
`ifdef LUARB_STALL_CNT_EN
    check_eq("stall_cnt_5", 64'(stall_cnt), 64'd5);
`endif

    // Reset pulse while a result is pending.
    req_valid = '1;
    res_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(res_valid), 64'd0);
    check_eq("midrst_ready", 64'(req_ready), 64'd0);
    check_eq("midrst_id", 64'(res_id), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    cycle();
    check_eq("postrst_id", 64'(res_id), 64'd0);
    check_eq("postrst_valid", 64'(res_valid), 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      req_valid = NREQ'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) set_slot(i, 3'($urandom), $urandom, $urandom);
      cycle();
    end

    // Idle: nothing driven to the LU, result drains and stays empty.
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) cycle();
    check_eq("idle_lu_op", 64'(lu_op), 64'd0);
    check_eq("idle_lu_a", 64'(lu_a), 64'd0);
    check_eq("idle_valid", 64'(res_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
